hsv_core_alu_share_arb: RTL and testbench

HSV_CORE_ALU_SHARE_ARB -- requirements
Module: hsv_core_alu_share_arb

---
 rtl/hsv_core_alu_share_arb.sv | 174 +++++++++++++++++
 tb/tb_hsv_core_alu_share_arb.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsv_core_alu_share_arb.sv
// hsv_core_alu_share_arb
// Shares one in-order ALU between N_REQ requesters.
// - Issue side: a combinational round-robin arbiter picks one requester and
//   forwards its payload to the ALU with no added latency.
// - Tag FIFO: records which requester issued each in-flight operation.
//   Because the ALU is in-order, the FIFO head owns the next result.
// - Flush: a small FSM forwards the core's flush to the ALU, discards results
//   while draining, and acknowledges the core for one cycle.
//
// Ports
//   clk_core, rst_core                      clock, async active-low reset
//   req_valid/req_ready/req_data            per-requester issue channel
//   alu_in_valid/alu_in_ready/alu_in_data   issue channel toward the ALU
//   alu_out_valid/alu_out_ready/alu_out_data result channel from the ALU
//   rsp_valid/rsp_ready/rsp_data            per-requester result channel (shared data)
//   flush_req/flush_ack                     flush handshake from the core
//   alu_flush_req/alu_flush_ack             flush handshake toward the ALU
module hsv_core_alu_share_arb #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 96,
  parameter int RES_W  = 64,
  parameter int DEPTH  = 4
) (
  input  logic                      clk_core,
  input  logic                      rst_core,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic                      alu_in_valid,
  input  logic                      alu_in_ready,
  output logic [DATA_W-1:0]         alu_in_data,
  input  logic                      alu_out_valid,
  output logic                      alu_out_ready,
  input  logic [RES_W-1:0]          alu_out_data,
  output logic [N_REQ-1:0]          rsp_valid,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic [RES_W-1:0]          rsp_data,
  input  logic                      flush_req,
  output logic                      flush_ack,
  output logic                      alu_flush_req,
  input  logic                      alu_flush_ack
);

  localparam int TAG_W = $clog2(N_REQ);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, ACK} flush_state_t;

  flush_state_t      state;
  flush_state_t      state_next;

  logic [TAG_W-1:0]  ptr;
  logic [TAG_W-1:0]  grant_idx;
  logic [TAG_W-1:0]  scan_idx;
  logic [TAG_W-1:0]  tag_mem [DEPTH];
  logic [TAG_W-1:0]  head_tag;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              fifo_empty;
  logic              fifo_full;
  logic              draining;
  logic              flush_start;
  logic              issue_block;
  logic              push;
  logic              pop;

  // Round-robin scan: walk offsets from the highest down so that the lowest
  // offset from ptr with a valid request is the last (winning) assignment.
  always_comb begin
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = TAG_W'((int'(ptr) + k) % N_REQ);
      if (req_valid[scan_idx]) begin
        grant_idx = scan_idx;
      end
    end
  end

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == CNT_W'(DEPTH));
  assign head_tag    = tag_mem[rd_ptr];
  assign draining    = (state == DRAIN);
  assign flush_start = (state == IDLE) && flush_req;
  // Any flush activity (including the request cycle itself) blocks issue.
  assign issue_block = (state != IDLE) || flush_req;

  // While draining every ALU result is accepted and dropped.
  assign alu_out_ready = draining || (rsp_ready[head_tag] && !fifo_empty);
  assign pop           = !draining && alu_out_valid && alu_out_ready;

  // A full FIFO may still accept a push when the head pops this cycle.
  assign alu_in_valid  = (|req_valid) && !issue_block && (!fifo_full || pop);
  assign push          = alu_in_valid && alu_in_ready;
  assign alu_in_data   = req_data[grant_idx*DATA_W +: DATA_W];

  assign rsp_data      = alu_out_data;
  assign flush_ack     = (state == ACK);
  assign alu_flush_req = (state == DRAIN);

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign req_ready[gi] = push && (grant_idx == TAG_W'(gi));
    assign rsp_valid[gi] = !draining && alu_out_valid && !fifo_empty &&
                           (head_tag == TAG_W'(gi));
  end

  // Flush FSM
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (flush_req) state_next = DRAIN;
      DRAIN:   if (alu_flush_ack) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_core or negedge rst_core) begin
    if (!rst_core) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arbiter pointer and tag FIFO bookkeeping
  always_ff @(posedge clk_core or negedge rst_core) begin
    if (!rst_core) begin
      ptr    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (flush_start || draining) begin
        ptr <= '0;
      end else if (push) begin
        ptr <= (grant_idx == TAG_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end

      if (draining) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Tag storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk_core) begin
    if (push) begin
      tag_mem[wr_ptr] <= grant_idx;
    end
  end

`ifndef SYNTHESIS
  // A result with no outstanding tag means the ALU broke the protocol.
  a_no_orphan_result : assert property (
    @(posedge clk_core) disable iff (!rst_core)
      ((state == IDLE) && alu_out_valid) |-> !fifo_empty
  );
`endif

endmodule

// File: tb/tb_hsv_core_alu_share_arb.sv
// Testbench for hsv_core_alu_share_arb: directed scenarios plus random traffic,
// checked against a queue-based behavioural model. The bench plays the ALU.
module tb_hsv_core_alu_share_arb;

  localparam int N  = 2;
  localparam int DW = 96;
  localparam int RW = 64;
  localparam int D  = 4;

  logic            clk_core;
  logic            rst_core;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data;
  logic            alu_in_valid;
  logic            alu_in_ready;
  logic [DW-1:0]   alu_in_data;
  logic            alu_out_valid;
  logic            alu_out_ready;
  logic [RW-1:0]   alu_out_data;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [RW-1:0]   rsp_data;
  logic            flush_req;
  logic            flush_ack;
  logic            alu_flush_req;
  logic            alu_flush_ack;

  hsv_core_alu_share_arb #(.N_REQ(N), .DATA_W(DW), .RES_W(RW), .DEPTH(D)) dut (
    .clk_core      (clk_core),
    .rst_core      (rst_core),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_data      (req_data),
    .alu_in_valid  (alu_in_valid),
    .alu_in_ready  (alu_in_ready),
    .alu_in_data   (alu_in_data),
    .alu_out_valid (alu_out_valid),
    .alu_out_ready (alu_out_ready),
    .alu_out_data  (alu_out_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .flush_req     (flush_req),
    .flush_ack     (flush_ack),
    .alu_flush_req (alu_flush_req),
    .alu_flush_ack (alu_flush_ack)
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  int total;
  int bad;

  // Reference model: phase 0 = normal, 1 = draining, 2 = acknowledging.
  int          m_phase;
  int          m_ptr;
  int          m_tags[$];
  logic [DW-1:0] alu_q[$];
  logic [DW-1:0] req_q[N][$];
  int          drain_cyc;
  bit          alu_hold;
  int          push_cnt;
  int          ack_cnt;
  logic [N-1:0] obs_req_ready;
  logic [N-1:0] obs_rsp_valid;
  logic         obs_out_ready;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] alu_fn(input logic [DW-1:0] p);
    return p[63:0] ^ {p[95:64], p[95:64]};
  endfunction

  task automatic rand_data();
    for (int i = 0; i < (N * DW) / 32; i++) req_data[i*32 +: 32] = $urandom();
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_ptr   = 0;
    m_tags.delete();
    alu_q.delete();
    for (int i = 0; i < N; i++) req_q[i].delete();
    drain_cyc = 0;
  endtask

  // The bench ALU presents its oldest result unless held, and acknowledges
  // a flush after two drain cycles.
  task automatic alu_drive();
    alu_out_valid = !alu_hold && (alu_q.size() > 0);
    alu_out_data  = (alu_q.size() > 0) ? alu_fn(alu_q[0]) : '0;
    alu_flush_ack = (m_phase == 1) && (drain_cyc >= 2);
  endtask

  // One clock: called at negedge with inputs set; checks, then advances model.
  task automatic cycle();
    int g;
    bit any;
    bit blocked;
    bit has;
    int head;
    bit e_pop;
    bit e_push;
    bit e_in_valid;
    logic [DW-1:0] pay;
    alu_drive();
    #2;
    g   = 0;
    any = 0;
    for (int k = 0; k < N; k++) begin
      if (!any && (((req_valid >> ((m_ptr + k) % N)) & 1) != 0)) begin
        g   = (m_ptr + k) % N;
        any = 1;
      end
    end
    pay     = req_data[g*DW +: DW];
    blocked = (m_phase != 0) || flush_req;
    has     = m_tags.size() > 0;
    head    = has ? m_tags[0] : 0;
    e_pop   = (m_phase != 1) && alu_out_valid && has && (((rsp_ready >> head) & 1) != 0);
    e_in_valid = !blocked && any && ((m_tags.size() < D) || e_pop);
    e_push  = e_in_valid && alu_in_ready;

    obs_req_ready = req_ready;
    obs_rsp_valid = rsp_valid;
    obs_out_ready = alu_out_ready;

    check_eq("alu_in_valid", alu_in_valid, e_in_valid);
    if (e_in_valid) check_eq("alu_in_data", alu_in_data, pay);
    check_eq("req_ready", req_ready, e_push ? (2'b01 << g) : 2'b00);
    check_eq("rsp_valid", rsp_valid,
             ((m_phase != 1) && alu_out_valid && has) ? (2'b01 << head) : 2'b00);
    check_eq("alu_out_ready", alu_out_ready,
             (m_phase == 1) ? 1'b1 : (has && (((rsp_ready >> head) & 1) != 0)));
    check_eq("flush_ack", flush_ack, m_phase == 2);
    check_eq("alu_flush_req", alu_flush_req, m_phase == 1);
    check_eq("rsp_data", rsp_data, alu_out_data);
    if (e_pop) check_eq("rsp_route", rsp_data, alu_fn(req_q[head][0]));

    @(posedge clk_core);
    if (alu_out_valid && ((m_phase == 1) || e_pop)) void'(alu_q.pop_front());
    if (e_pop) begin
      void'(m_tags.pop_front());
      void'(req_q[head].pop_front());
    end
    if (e_push) begin
      m_tags.push_back(g);
      alu_q.push_back(pay);
      req_q[g].push_back(pay);
      m_ptr = (g + 1) % N;
      push_cnt++;
    end
    if ((m_phase == 1) && alu_flush_ack) alu_q.delete();
    case (m_phase)
      0: if (flush_req) begin
           m_phase   = 1;
           m_ptr     = 0;
           drain_cyc = 0;
         end
      1: begin
           m_tags.delete();
           for (int i = 0; i < N; i++) req_q[i].delete();
           drain_cyc++;
           if (alu_flush_ack) m_phase = 2;
         end
      default: begin
           m_phase = 0;
           ack_cnt++;
         end
    endcase
    @(negedge clk_core);
  endtask

  task automatic drain();
    req_valid = '0;
    flush_req = 1'b0;
    alu_hold  = 1'b0;
    rsp_ready = 2'b11;
    for (int i = 0; i < 20 && (alu_q.size() > 0 || m_phase != 0); i++) cycle();
  endtask

  int p0;
  int a0;
  int w;

  initial begin
    total = 0; bad = 0; push_cnt = 0; ack_cnt = 0;
    rst_core = 1'b0;
    req_valid = '0; req_data = '0; alu_in_ready = 1'b0;
    alu_out_valid = 1'b0; alu_out_data = '0; rsp_ready = '0;
    flush_req = 1'b0; alu_flush_ack = 1'b0; alu_hold = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk_core);
    #1;
    check_eq("rst_flush_ack", flush_ack, 1'b0);
    check_eq("rst_alu_flush_req", alu_flush_req, 1'b0);
    check_eq("rst_alu_in_valid", alu_in_valid, 1'b0);
    check_eq("rst_rsp_valid", rsp_valid, 2'b00);
    @(negedge clk_core);
    rst_core = 1'b1;

    // Alternating grants with one result per cycle
    alu_in_ready = 1'b1;
    rsp_ready    = 2'b11;
    req_valid    = 2'b11;
    for (int c = 0; c < 8; c++) begin
      rand_data();
      cycle();
      check_eq("alt_grant", obs_req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
    end
    drain();

    // Fill to DEPTH with results held, then issue together with a pop
    alu_hold  = 1'b1;
    req_valid = 2'b11;
    p0 = push_cnt;
    for (int c = 0; c < 8; c++) begin
      rand_data();
      cycle();
    end
    check_eq("fill_depth", push_cnt - p0, D);
    alu_hold = 1'b0;
    rand_data();
    cycle();
    check_eq("issue_with_pop", obs_req_ready != 2'b00, 1'b1);
    drain();

    // Flush with 3 in flight; request held to prove issue is blocked
    alu_hold  = 1'b1;
    req_valid = 2'b11;
    for (int c = 0; c < 3; c++) begin
      rand_data();
      cycle();
    end
    a0 = ack_cnt;
    flush_req = 1'b1;
    cycle();
    check_eq("flush_priority", obs_req_ready, 2'b00);
    flush_req = 1'b0;
    alu_hold  = 1'b0;
    w = 0;
    while (m_phase != 0 && w < 20) begin
      cycle();
      w++;
    end
    check_eq("flush_done", w < 20, 1'b1);
    check_eq("flush_ack_once", ack_cnt - a0, 1);
    // ptr and occupancy cleared: first grant to 0, then exactly DEPTH issues
    alu_hold = 1'b1;
    p0 = push_cnt;
    for (int c = 0; c < 6; c++) begin
      rand_data();
      cycle();
      if (c == 0) check_eq("ptr_after_flush", obs_req_ready, 2'b01);
    end
    check_eq("occ_after_flush", push_cnt - p0, D);
    drain();

    // Only requester 1, then both: 1 first, then 0 after ptr wraps
    alu_hold  = 1'b1;
    req_valid = 2'b10;
    rand_data();
    cycle();
    check_eq("solo_grant1", obs_req_ready, 2'b10);
    req_valid = 2'b11;
    rand_data();
    cycle();
    check_eq("wrap_grant0", obs_req_ready, 2'b01);
    // Head tag 1 stalls on rsp_ready[1]=0
    req_valid = 2'b00;
    alu_hold  = 1'b0;
    rsp_ready = 2'b01;
    for (int c = 0; c < 3; c++) begin
      cycle();
      check_eq("stall_out_ready", obs_out_ready, 1'b0);
      check_eq("stall_rsp_valid", obs_rsp_valid, 2'b10);
    end
    drain();

    // Asynchronous reset with 2 in flight, no clock edge needed
    alu_hold  = 1'b1;
    req_valid = 2'b11;
    for (int c = 0; c < 2; c++) begin
      rand_data();
      cycle();
    end
    req_valid = 2'b00;
    #2;
    rst_core = 1'b0;
    #1;
    check_eq("arst_alu_in_valid", alu_in_valid, 1'b0);
    check_eq("arst_flush_ack", flush_ack, 1'b0);
    check_eq("arst_alu_flush_req", alu_flush_req, 1'b0);
    alu_out_valid = 1'b1;
    rsp_ready     = 2'b11;
    #1;
    check_eq("arst_rsp_valid", rsp_valid, 2'b00);
    check_eq("arst_out_ready", alu_out_ready, 1'b0);
    alu_out_valid = 1'b0;
    model_reset();
    @(negedge clk_core);
    @(negedge clk_core);
    rst_core = 1'b1;
    alu_hold = 1'b0;

    // Random traffic with occasional flushes
    for (int c = 0; c < 600; c++) begin
      req_valid    = N'($urandom_range(0, 3));
      rand_data();
      alu_in_ready = ($urandom_range(0, 3) != 0);
      rsp_ready    = N'($urandom_range(0, 3));
      alu_hold     = ($urandom_range(0, 2) == 0);
      flush_req    = (m_phase == 0) ? ($urandom_range(0, 39) == 0)
                                    : ($urandom_range(0, 3) == 0);
      cycle();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
